// File: rtl/mod_exp_seq.sv
// Left-to-right square-and-multiply modular exponentiator.
// Ports: clk/reset, start/base/exponent in, busy/done/result out, mul_* multiplier link.
module mod_exp_seq #(
  parameter int               width = 128,
  parameter logic [width-1:0] p     = 128'd37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] base,
  input  logic [width-1:0] exponent,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] result,
  output logic             mul_start,
  output logic [width-1:0] mul_a,
  output logic [width-1:0] mul_b,
  input  logic [width-1:0] mul_r,
  input  logic             mul_done
);

  localparam int iw = (width > 1) ? $clog2(width) : 1;
  localparam logic [width-1:0] one_mod_p = width'(1) % p;

  typedef enum logic [2:0] {
    s_idle,
    s_scan,
    s_sqr,
    s_sqr_w,
    s_mul,
    s_mul_w,
    s_fin
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [width-1:0] acc;
  logic [width-1:0] base_q;
  logic [width-1:0] exp_q;
  logic [iw-1:0]    idx;
  logic [width-1:0] result_q;
  logic             idx_last;
  logic             bit_set;

  assign idx_last = (idx == '0);
  assign bit_set  = exp_q[idx];
  assign result   = result_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= s_idle;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      s_idle:  if (start) state_nx = s_scan;
      s_scan: begin
        if (exp_q == '0)  state_nx = s_fin;
        else if (bit_set) state_nx = idx_last ? s_fin : s_sqr;
      end
      s_sqr:   state_nx = s_sqr_w;
      s_sqr_w: begin
        if (mul_done) begin
          if (bit_set)       state_nx = s_mul;
          else if (idx_last) state_nx = s_fin;
          else               state_nx = s_sqr;
        end
      end
      s_mul:   state_nx = s_mul_w;
      s_mul_w: begin
        if (mul_done) state_nx = idx_last ? s_fin : s_sqr;
      end
      s_fin:   state_nx = s_idle;
      default: state_nx = s_idle;
    endcase
  end

  // idx is only decremented after the idx==0 test, so it never wraps.
  // result is loaded on the edge entering s_fin so it is valid with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      idx      <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        s_idle: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exponent;
            idx    <= iw'(width - 1);
          end
        end
        s_scan: begin
          if (exp_q == '0) begin
            acc      <= one_mod_p;
            result_q <= one_mod_p;
          end else if (bit_set) begin
            acc <= base_q;
            if (idx_last) result_q <= base_q;
            else          idx      <= idx - 1'b1;
          end else if (!idx_last) begin
            idx <= idx - 1'b1;
          end
        end
        s_sqr_w: begin
          if (mul_done) begin
            acc <= mul_r;
            if (!bit_set) begin
              if (idx_last) result_q <= mul_r;
              else          idx      <= idx - 1'b1;
            end
          end
        end
        s_mul_w: begin
          if (mul_done) begin
            acc <= mul_r;
            if (idx_last) result_q <= mul_r;
            else          idx      <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // acc only changes on the mul_done edge that leaves a wait state,
  // so operands stay stable for the whole request.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    unique case (state)
      s_idle:  ;
      s_scan:  busy = 1'b1;
      s_sqr: begin
        busy      = 1'b1;
        mul_start = 1'b1;
        mul_a     = acc;
        mul_b     = acc;
      end
      s_sqr_w: begin
        busy  = 1'b1;
        mul_a = acc;
        mul_b = acc;
      end
      s_mul: begin
        busy      = 1'b1;
        mul_start = 1'b1;
        mul_a     = acc;
        mul_b     = base_q;
      end
      s_mul_w: begin
        busy  = 1'b1;
        mul_a = acc;
        mul_b = base_q;
      end
      s_fin:   done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mod_exp_seq.md
Name: mod_exp_seq

Overview:
- Sequential modular exponentiator: computes result = base^exponent mod p with left-to-right square-and-multiply.
- Sits directly downstream of the modular multiplier. It sequences operand pairs into the multiplier and consumes each product, one request outstanding at a time.
- Primary use in the MSM datapath is the Fermat inverse (exponent = p-2) for affine conversion. Any exponent is supported.

Parameters:
- width, 128, operand/result bit width (matches multiplier width).
- p, 128'd37, prime modulus; required p > 2. Used only for the exponent-0 result; the multiplier owns reduction.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base  input  width  operand, sampled with start; contract: base < p.
- exponent  input  width  exponent, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is valid.
- result  output  width  final value, held until the next accepted start.
- mul_start  output  1  one-cycle pulse issuing a multiply request.
- mul_a  output  width  multiplier operand A, stable from mul_start until mul_done.
- mul_b  output  width  multiplier operand B, stable from mul_start until mul_done.
- mul_r  input  width  product (mod p) from the multiplier; valid when mul_done=1.
- mul_done  input  1  one-cycle pulse from the multiplier; any latency of 1 cycle or more.

Behaviour:
- Reset values: busy=0, done=0, result=0, mul_start=0, mul_a=0, mul_b=0; FSM in IDLE; internal acc, idx and latched operands cleared.
- IDLE:
  - On start=1, latch base and exponent, set idx=width-1, busy=1 next cycle, go to SCAN.
  - start while busy is ignored (no re-latch, no effect on the running operation).
- SCAN (one bit per cycle):
  - Exponent==0: go to FIN with acc=1.
  - Else if exponent[idx]=1: acc=base. If idx==0, go to FIN; otherwise decrement idx and go to SQR.
  - Else decrement idx and stay in SCAN.
  - SCAN length = width - (index of MSB set), in cycles.
- SQR: drive mul_a=acc, mul_b=acc, pulse mul_start for one cycle, then go to SQR_W.
- SQR_W:
  - On mul_done: acc=mul_r.
  - If exponent[idx]=1, go to MUL.
  - Else if idx==0, go to FIN; otherwise decrement idx and go to SQR.
- MUL: drive mul_a=acc, mul_b=base, pulse mul_start, then go to MUL_W.
- MUL_W: on mul_done, acc=mul_r. If idx==0 go to FIN; otherwise decrement idx and go to SQR.
- FIN: result=acc, done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE. The next start is accepted in the following cycle.
- Request count: exactly (bitlen(e)-1) squares plus (popcount(e)-1) multiplies; zero requests for e=0 or e=1.
- mul_done outside SQR_W/MUL_W is ignored. mul_start never reasserts before the matching mul_done.
- Reset mid-operation: return to IDLE immediately and clear outputs. A stale mul_done arriving after reset is ignored. No done pulse is produced for the aborted operation.
- Width rules:
  - acc, mul_a, mul_b and result are all width bits.
  - idx is clog2(width) bits and never wraps: the idx==0 check precedes any decrement.
- Exponent 1 returns base unmodified (relies on the base<p contract).

Test Plan:
- 3^5 with p=37, 3-cycle multiplier model -> result=21; exactly 3 mul_start pulses (sqr, sqr, mul); done pulses once.
- Fermat inverse: base=5, exponent=35 -> result=15 (5*15 mod 37 = 1); exactly 7 mul_start pulses; mul_a/mul_b stable throughout each wait.
- Exponent=0, base=9 -> result=1, no mul_start. Exponent=1, base=7 -> result=7, no mul_start.
- start re-pulsed with base=2, exponent=3 during the 3^5 run -> ignored; result=21; then a new start after done -> result=8.
- reset asserted while in SQR_W of the 5^35 run, with mul_done arriving 1 cycle after reset release -> all outputs 0, FSM IDLE, no done. A subsequent 3^5 run gives 21.
- Multiplier latency swept 1..10 cycles on 5^35 -> result always 15; done latency = SCAN cycles + sum of (issue+wait) cycles + 1.
